// File: rtl/andor_pkg.sv
// Shared constants and types for the andor switch/LED slice.
// Debounce depth is derived from the fabric clock so that one setting gives 1 ms.
package andor_pkg;

   localparam int SW_WIDTH                = 32'd2;
   localparam int LED_WIDTH               = 32'd6;
   localparam int FAB_CLK_HZ              = 32'd100_000_000;
   localparam int DEBOUNCE_MS             = 32'd1;
   localparam int DEBOUNCE_CYCLES_DEFAULT = (FAB_CLK_HZ / 32'd1000) * DEBOUNCE_MS;
   localparam int CNT_W_DEFAULT           = 32'd24;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } lane_out_t;

   // Returns {rise, fall} for an accepted transition towards new_level.
   function automatic logic [1:0] edge_of(input logic new_level);
      logic [1:0] strobes;
      if (new_level) begin
         strobes = 2'b10;
      end else begin
         strobes = 2'b01;
      end
      return strobes;
   endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw pins in, clean levels and edge strobes out.
interface sw_debounce_if #(
   parameter int WIDTH = andor_pkg::SW_WIDTH
);
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_out;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;

   modport master (output sw_raw, input sw_out, input sw_rise, input sw_fall);
   modport slave  (input sw_raw, output sw_out, output sw_rise, output sw_fall);
endinterface

// File: rtl/debounce_lane.sv
// One switch bit: two-flop synchroniser, stability counter and registered strobes.
module debounce_lane
   import andor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = CNT_W_DEFAULT
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      sw_raw,
   output lane_out_t lane
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_r;
   logic             s2_r;
   logic [CNT_W-1:0] cnt_r;
   lane_out_t        lane_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   lane_out_t        lane_nxt_s;

   // Synchroniser flops; only s2_r is consumed downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= sw_raw;
         s2_r <= s1_r;
      end
   end

   // Next-state: count while s2 disagrees with the accepted level, accept at CNT_MAX.
   always_comb begin
      cnt_nxt_s        = {CNT_W{1'b0}};
      lane_nxt_s       = lane_r;
      lane_nxt_s.rise  = 1'b0;
      lane_nxt_s.fall  = 1'b0;
      if (s2_r == lane_r.level) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
         lane_nxt_s.level                   = s2_r;
         {lane_nxt_s.rise, lane_nxt_s.fall} = edge_of(s2_r);
         cnt_nxt_s                          = {CNT_W{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Counter, accepted level and strobes registered together so they stay aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r  <= {CNT_W{1'b0}};
         lane_r <= '{level: 1'b0, rise: 1'b0, fall: 1'b0};
      end else begin
         cnt_r  <= cnt_nxt_s;
         lane_r <= lane_nxt_s;
      end
   end

   assign lane = lane_r;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH raw slide switches into clean levels plus rise/fall strobes.
module sw_debounce
   import andor_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = CNT_W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   sw_debounce_if.slave sw_bus
);

   lane_out_t        lane_s [WIDTH];
   logic [WIDTH-1:0] out_s;
   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      debounce_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .sw_raw (sw_bus.sw_raw[i]),
         .lane   (lane_s[i])
      );
   end

   // Repack per-lane register outputs into bus vectors (pure wiring).
   always_comb begin
      out_s  = {WIDTH{1'b0}};
      rise_s = {WIDTH{1'b0}};
      fall_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         out_s[i]  = lane_s[i].level;
         rise_s[i] = lane_s[i].rise;
         fall_s[i] = lane_s[i].fall;
      end
   end

   assign sw_bus.sw_out  = out_s;
   assign sw_bus.sw_rise = rise_s;
   assign sw_bus.sw_fall = fall_s;

endmodule
